fp_mul_pipe: RTL and testbench

- Parametrised pipelined IEEE-754-style floating-point multiplier; generalises the FP32 multiplier to any exponent/mantissa width.
- Adds a full valid/ready backpressure handshake, special-value handling (zero, inf, NaN), overflow/underflow saturation and exception flags.
- Optional round-to-nearest-even.
- Sits in the NLA datapath wherever activation-approximation polynomials need FP products.

---
 rtl/fp_mul_pipe_if.sv | 24 ++
 rtl/fp_mul_pipe.sv | 264 ++++++++++++++++++++++++++
 tb/tb_fp_mul_pipe.sv | 328 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fp_mul_pipe_if.sv
// Operand/result handshake bundle for fp_mul_pipe: valid/ready on both the operand and result sides.
// The slave modport is the multiplier's view. The master modport is the producer/consumer view.
interface fp_mul_pipe_if #(
    parameter int W = 32
);
    logic         valid_i;
    logic         ready_o;
    logic [W-1:0] a_i;
    logic [W-1:0] b_i;
    logic         valid_o;
    logic         ready_i;
    logic [W-1:0] result_o;
    logic [3:0]   flags_o;

    modport master (
        output valid_i, a_i, b_i, ready_i,
        input  ready_o, valid_o, result_o, flags_o
    );

    modport slave (
        input  valid_i, a_i, b_i, ready_i,
        output ready_o, valid_o, result_o, flags_o
    );
endinterface

// File: rtl/fp_mul_pipe.sv
// Pipelined parametrised floating-point multiplier with valid/ready backpressure, FTZ and saturation.
// Optional macro FP_MUL_RNE_EN selects round-to-nearest-even; without it results are truncated.
module fp_mul_pipe #(
    parameter int EXP_W      = 8,
    parameter int MAN_W      = 23,
    parameter int MUL_STAGES = 2
) (
    input  logic         clk_i,
    input  logic         rstn_i,
    fp_mul_pipe_if.slave bus
);
    localparam int MW = MAN_W + 1;
    localparam int PW = 2 * MW;
    localparam int SW = EXP_W + 2;
    localparam int RW = 1 + EXP_W + MAN_W;

    localparam logic signed [SW-1:0] BIAS_S    = SW'((2 ** (EXP_W - 1)) - 1);
    localparam logic signed [SW-1:0] EMAX_S    = SW'((2 ** EXP_W) - 1);
    localparam logic signed [SW-1:0] ONE_S     = SW'(1);
    localparam logic signed [SW-1:0] ZERO_S    = SW'(0);
    localparam logic [EXP_W-1:0]     EXP_ONES  = {EXP_W{1'b1}};
    localparam logic [EXP_W-1:0]     EXP_ZERO  = {EXP_W{1'b0}};
    localparam logic [MAN_W-1:0]     FRAC_ZERO = {MAN_W{1'b0}};
    localparam logic [MAN_W-1:0]     FRAC_QNAN = {1'b1, {(MAN_W-1){1'b0}}};

    // Result class is decided at unpack time and applied at pack time.
    typedef enum logic [1:0] {
        CLS_NORM = 2'd0,
        CLS_NAN  = 2'd1,
        CLS_INF  = 2'd2,
        CLS_ZERO = 2'd3
    } cls_t;

    logic            en_s;
    logic            out_valid_r;
    logic [RW-1:0]   out_result_r;
    logic [3:0]      out_flags_r;

    assign en_s         = !out_valid_r || bus.ready_i;
    assign bus.ready_o  = en_s;
    assign bus.valid_o  = out_valid_r;
    assign bus.result_o = out_result_r;
    assign bus.flags_o  = out_flags_r;

    logic             sa_s, sb_s;
    logic [EXP_W-1:0] ea_s, eb_s;
    logic [MAN_W-1:0] fa_s, fb_s;
    logic             a_zero_s, a_inf_s, a_nan_s, a_snan_s;
    logic             b_zero_s, b_inf_s, b_nan_s, b_snan_s;
    cls_t             cls_s;
    logic             inv_s;
    logic signed [SW-1:0] esum_s;

    assign {sa_s, ea_s, fa_s} = bus.a_i;
    assign {sb_s, eb_s, fb_s} = bus.b_i;

    assign a_zero_s = (ea_s == EXP_ZERO);
    assign a_inf_s  = (ea_s == EXP_ONES) && (fa_s == FRAC_ZERO);
    assign a_nan_s  = (ea_s == EXP_ONES) && (fa_s != FRAC_ZERO);
    assign a_snan_s = a_nan_s && !fa_s[MAN_W-1];
    assign b_zero_s = (eb_s == EXP_ZERO);
    assign b_inf_s  = (eb_s == EXP_ONES) && (fb_s == FRAC_ZERO);
    assign b_nan_s  = (eb_s == EXP_ONES) && (fb_s != FRAC_ZERO);
    assign b_snan_s = b_nan_s && !fb_s[MAN_W-1];

    assign esum_s = $signed({2'b00, ea_s}) + $signed({2'b00, eb_s}) - BIAS_S;

    // Special-value priority: NaN, inf*zero, inf, zero, then the normal path.
    always_comb begin
        cls_s = CLS_NORM;
        inv_s = 1'b0;
        if (a_nan_s || b_nan_s) begin
            cls_s = CLS_NAN;
            inv_s = a_snan_s || b_snan_s;
        end else if ((a_inf_s && b_zero_s) || (b_inf_s && a_zero_s)) begin
            cls_s = CLS_NAN;
            inv_s = 1'b1;
        end else if (a_inf_s || b_inf_s) begin
            cls_s = CLS_INF;
        end else if (a_zero_s || b_zero_s) begin
            cls_s = CLS_ZERO;
        end else begin
            cls_s = CLS_NORM;
        end
    end

    logic                 u_valid_r;
    logic                 u_sign_r;
    logic signed [SW-1:0] u_esum_r;
    cls_t                 u_cls_r;
    logic                 u_inv_r;
    logic [MAN_W-1:0]     u_fa_r;
    logic [MAN_W-1:0]     u_fb_r;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            u_valid_r <= 1'b0;
            u_sign_r  <= 1'b0;
            u_esum_r  <= ZERO_S;
            u_cls_r   <= CLS_NORM;
            u_inv_r   <= 1'b0;
            u_fa_r    <= FRAC_ZERO;
            u_fb_r    <= FRAC_ZERO;
        end else if (en_s) begin
            u_valid_r <= bus.valid_i;
            if (bus.valid_i) begin
                u_sign_r <= sa_s ^ sb_s;
                u_esum_r <= esum_s;
                u_cls_r  <= cls_s;
                u_inv_r  <= inv_s;
                u_fa_r   <= fa_s;
                u_fb_r   <= fb_s;
            end
        end
    end

    logic                 m_valid_r [MUL_STAGES];
    logic                 m_sign_r  [MUL_STAGES];
    logic signed [SW-1:0] m_esum_r  [MUL_STAGES];
    cls_t                 m_cls_r   [MUL_STAGES];
    logic                 m_inv_r   [MUL_STAGES];
    logic [PW-1:0]        m_prod_r  [MUL_STAGES];

    // Mantissa product is formed into the first stage; later stages only delay it.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            for (int i = 0; i < MUL_STAGES; i++) begin
                m_valid_r[i] <= 1'b0;
                m_sign_r[i]  <= 1'b0;
                m_esum_r[i]  <= ZERO_S;
                m_cls_r[i]   <= CLS_NORM;
                m_inv_r[i]   <= 1'b0;
                m_prod_r[i]  <= {PW{1'b0}};
            end
        end else if (en_s) begin
            m_valid_r[0] <= u_valid_r;
            m_sign_r[0]  <= u_sign_r;
            m_esum_r[0]  <= u_esum_r;
            m_cls_r[0]   <= u_cls_r;
            m_inv_r[0]   <= u_inv_r;
            m_prod_r[0]  <= PW'({1'b1, u_fa_r}) * PW'({1'b1, u_fb_r});
            for (int i = 1; i < MUL_STAGES; i++) begin
                m_valid_r[i] <= m_valid_r[i-1];
                m_sign_r[i]  <= m_sign_r[i-1];
                m_esum_r[i]  <= m_esum_r[i-1];
                m_cls_r[i]   <= m_cls_r[i-1];
                m_inv_r[i]   <= m_inv_r[i-1];
                m_prod_r[i]  <= m_prod_r[i-1];
            end
        end
    end

    logic [PW-1:0] p_s;
    logic [PW-2:0] pn_s;
    logic          top_s;
    logic signed [SW-1:0] e_norm_s;

    // Product lies in [1,4): one-bit normalisation drops the leading one.
    assign p_s      = m_prod_r[MUL_STAGES-1];
    assign top_s    = p_s[PW-1];
    assign pn_s     = top_s ? p_s[PW-2:0] : {p_s[PW-3:0], 1'b0};
    assign e_norm_s = top_s ? (m_esum_r[MUL_STAGES-1] + ONE_S) : m_esum_r[MUL_STAGES-1];

    logic                 n_valid_r;
    logic                 n_sign_r;
    logic signed [SW-1:0] n_e_r;
    cls_t                 n_cls_r;
    logic                 n_inv_r;
    logic [MAN_W-1:0]     n_frac_r;
    logic                 n_guard_r;
    logic                 n_sticky_r;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            n_valid_r  <= 1'b0;
            n_sign_r   <= 1'b0;
            n_e_r      <= ZERO_S;
            n_cls_r    <= CLS_NORM;
            n_inv_r    <= 1'b0;
            n_frac_r   <= FRAC_ZERO;
            n_guard_r  <= 1'b0;
            n_sticky_r <= 1'b0;
        end else if (en_s) begin
            n_valid_r  <= m_valid_r[MUL_STAGES-1];
            n_sign_r   <= m_sign_r[MUL_STAGES-1];
            n_e_r      <= e_norm_s;
            n_cls_r    <= m_cls_r[MUL_STAGES-1];
            n_inv_r    <= m_inv_r[MUL_STAGES-1];
            n_frac_r   <= pn_s[PW-2 -: MAN_W];
            n_guard_r  <= pn_s[MAN_W];
            n_sticky_r <= |pn_s[MAN_W-1:0];
        end
    end

    logic signed [SW-1:0] e_rnd_s;
    logic [MAN_W-1:0]     frac_rnd_s;

`ifdef FP_MUL_RNE_EN
    logic             inc_s;
    logic [MAN_W:0]   frac_sum_s;

    // A carry out of the fraction leaves it all-zero and bumps the exponent.
    assign inc_s      = n_guard_r && (n_sticky_r || n_frac_r[0]);
    assign frac_sum_s = {1'b0, n_frac_r} + {{MAN_W{1'b0}}, inc_s};
    assign frac_rnd_s = frac_sum_s[MAN_W-1:0];
    assign e_rnd_s    = frac_sum_s[MAN_W] ? (n_e_r + ONE_S) : n_e_r;
`else
    assign frac_rnd_s = n_frac_r;
    assign e_rnd_s    = n_e_r;
`endif

    logic [RW-1:0] res_s;
    logic [3:0]    flg_s;

    // Pack the result and exception flags {invalid, overflow, underflow, inexact}.
    always_comb begin
        res_s = {RW{1'b0}};
        flg_s = 4'b0000;
        case (n_cls_r)
            CLS_NAN: begin
                res_s = {1'b0, EXP_ONES, FRAC_QNAN};
                flg_s = {n_inv_r, 3'b000};
            end
            CLS_INF: begin
                res_s = {n_sign_r, EXP_ONES, FRAC_ZERO};
                flg_s = 4'b0000;
            end
            CLS_ZERO: begin
                res_s = {n_sign_r, EXP_ZERO, FRAC_ZERO};
                flg_s = 4'b0000;
            end
            CLS_NORM: begin
                if (e_rnd_s >= EMAX_S) begin
                    res_s = {n_sign_r, EXP_ONES, FRAC_ZERO};
                    flg_s = 4'b0101;
                end else if (e_rnd_s <= ZERO_S) begin
                    res_s = {n_sign_r, EXP_ZERO, FRAC_ZERO};
                    flg_s = 4'b0011;
                end else begin
                    res_s = {n_sign_r, e_rnd_s[EXP_W-1:0], frac_rnd_s};
                    flg_s = {3'b000, n_guard_r || n_sticky_r};
                end
            end
            default: begin
                res_s = {RW{1'b0}};
                flg_s = 4'b0000;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            out_valid_r  <= 1'b0;
            out_result_r <= {RW{1'b0}};
            out_flags_r  <= 4'b0000;
        end else if (en_s) begin
            out_valid_r <= n_valid_r;
            if (n_valid_r) begin
                out_result_r <= res_s;
                out_flags_r  <= flg_s;
            end
        end
    end
endmodule

// File: tb/tb_fp_mul_pipe.sv
// Self-checking bench for fp_mul_pipe: FP32 instance against an arithmetic reference model,
// plus a small FP16 instance. Honours FP_MUL_RNE_EN for the rounding mode.
module tb_fp_mul_pipe;
    logic clk = 1'b0;
    logic rstn = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   out_cnt = 0;
    bit   rand_rdy = 1'b0;
    logic [35:0] exp_q[$];

    always #5 clk = ~clk;

    fp_mul_pipe_if #(.W(32)) bus ();
    fp_mul_pipe_if #(.W(16)) bus16 ();

    fp_mul_pipe dut (.clk_i(clk), .rstn_i(rstn), .bus(bus));
    fp_mul_pipe #(.EXP_W(5), .MAN_W(10), .MUL_STAGES(2)) dut16 (.clk_i(clk), .rstn_i(rstn), .bus(bus16));

`ifdef FP_MUL_RNE_EN
    localparam logic [35:0] TIE_EXP = {4'h1, 32'h3FC00002};
`else
    localparam logic [35:0] TIE_EXP = {4'h1, 32'h3FC00001};
`endif

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, exp);
        end
    endtask

    // Reference: exact integer product of the significands, then rounding on the remainder.
    function automatic logic [35:0] model(input logic [31:0] a, input logic [31:0] b);
        logic s;
        int ea, eb, e, sh;
        longint unsigned ma, mb, p, q, rem;
        bit an, bn, ai, bi, az, bz, inx;
        s  = a[31] ^ b[31];
        ea = int'(a[30:23]);
        eb = int'(b[30:23]);
        an = (ea == 255) && (a[22:0] != 23'd0);
        bn = (eb == 255) && (b[22:0] != 23'd0);
        ai = (ea == 255) && (a[22:0] == 23'd0);
        bi = (eb == 255) && (b[22:0] == 23'd0);
        az = (ea == 0);
        bz = (eb == 0);
        if (an || bn) return {(an && !a[22]) || (bn && !b[22]), 3'b000, 32'h7FC00000};
        if ((ai && bz) || (bi && az)) return {4'b1000, 32'h7FC00000};
        if (ai || bi) return {4'b0000, s, 8'hFF, 23'd0};
        if (az || bz) return {4'b0000, s, 31'd0};
        ma = 64'(a[22:0]) + (64'd1 << 23);
        mb = 64'(b[22:0]) + (64'd1 << 23);
        p  = ma * mb;
        e  = ea + eb - 127;
        if (p >= (64'd1 << 47)) begin
            e++;
            sh = 24;
        end else begin
            sh = 23;
        end
        q   = p >> sh;
        rem = p - (q << sh);
        inx = (rem != 64'd0);
`ifdef FP_MUL_RNE_EN
        if ((rem > (64'd1 << (sh - 1))) || ((rem == (64'd1 << (sh - 1))) && q[0])) q = q + 64'd1;
        if (q == (64'd1 << 24)) begin
            q = 64'd1 << 23;
            e++;
        end
`endif
        if (e >= 255) return {4'b0101, s, 8'hFF, 23'd0};
        if (e <= 0) return {4'b0011, s, 31'd0};
        return {3'b000, inx, s, 8'(e), q[22:0]};
    endfunction

    function automatic logic [31:0] rand_op();
        logic s;
        logic [7:0] e;
        logic [22:0] f;
        s = 1'($urandom_range(0, 1));
        f = 23'($urandom);
        case ($urandom_range(0, 11))
            0:       e = 8'd0;
            1:       begin e = 8'hFF; f = 23'd0; end
            2:       e = 8'hFF;
            3:       e = 8'($urandom_range(1, 4));
            4:       e = 8'($urandom_range(250, 254));
            5:       begin e = 8'($urandom_range(100, 150)); f = f & 23'h7F0000; end
            6:       begin e = 8'($urandom_range(100, 150)); f = 23'h7FFFFF; end
            default: e = 8'($urandom_range(1, 254));
        endcase
        return {s, e, f};
    endfunction

    // Compare process: scoreboard push on acceptance, pop/compare on every output transfer.
    initial begin : monitor
        logic hold;
        logic [31:0] hr;
        logic [3:0] hf;
        logic [35:0] e;
        hold = 1'b0;
        hr = 32'd0;
        hf = 4'd0;
        forever begin
            @(negedge clk);
            if (!rstn) begin
                hold = 1'b0;
            end else begin
                chk("ready_rule", bus.ready_o, !bus.valid_o || bus.ready_i);
                if (hold) begin
                    chk("hold_valid", bus.valid_o, 1'b1);
                    chk("hold_result", bus.result_o, hr);
                    chk("hold_flags", bus.flags_o, hf);
                end
                if (bus.valid_i && bus.ready_o) exp_q.push_back(model(bus.a_i, bus.b_i));
                if (bus.valid_o && bus.ready_i) begin
                    out_cnt++;
                    if (exp_q.size() == 0) begin
                        chk("unexpected_out", bus.result_o, 32'hDEAD0000);
                    end else begin
                        e = exp_q.pop_front();
                        chk("out_result", bus.result_o, e[31:0]);
                        chk("out_flags", bus.flags_o, e[35:32]);
                    end
                end
                hold = bus.valid_o && !bus.ready_i;
                hr = bus.result_o;
                hf = bus.flags_o;
            end
        end
    end

    initial begin : rand_ready
        forever begin
            @(posedge clk);
            #1;
            if (rand_rdy) bus.ready_i = ($urandom_range(0, 3) != 0);
        end
    end

    task automatic send(input logic [31:0] a, input logic [31:0] b);
        int t;
        t = 0;
        bus.valid_i = 1'b1;
        bus.a_i = a;
        bus.b_i = b;
        @(negedge clk);
        while (!bus.ready_o && t < 100) begin
            @(negedge clk);
            t++;
        end
        chk("send_progress", t < 100, 1'b1);
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 300) begin
            @(posedge clk);
            #1;
            t++;
        end
        chk("drain", exp_q.size(), 0);
    endtask

    task automatic measure(input string nm, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] er, input logic [3:0] ef);
        int lat;
        bus.valid_i = 1'b1;
        bus.a_i = a;
        bus.b_i = b;
        @(posedge clk);
        #1;
        bus.valid_i = 1'b0;
        lat = 1;
        while (!bus.valid_o && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk({nm, "_latency"}, lat, 5);
        chk({nm, "_result"}, bus.result_o, er);
        chk({nm, "_flags"}, bus.flags_o, ef);
        @(posedge clk);
        #1;
    endtask

    initial begin : main
        int lat, cnt0;
        bus.valid_i = 1'b0;
        bus.a_i = 32'd0;
        bus.b_i = 32'd0;
        bus.ready_i = 1'b1;
        bus16.valid_i = 1'b0;
        bus16.a_i = 16'd0;
        bus16.b_i = 16'd0;
        bus16.ready_i = 1'b1;

        #2 rstn = 1'b0;
        #1;
        chk("rst_valid", bus.valid_o, 1'b0);
        chk("rst_result", bus.result_o, 32'd0);
        chk("rst_flags", bus.flags_o, 4'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_ready", bus.ready_o, 1'b1);

        // Hand-computed values pinning the reference model.
        chk("pin_basic", model(32'h3FC00000, 32'h40000000), {4'h0, 32'h40400000});
        chk("pin_tie", model(32'h3F800001, 32'h3FC00000), TIE_EXP);
        chk("pin_inf_zero", model(32'h7F800000, 32'h00000000), {4'h8, 32'h7FC00000});
        chk("pin_ninf", model(32'hFF800000, 32'h40000000), {4'h0, 32'hFF800000});
        chk("pin_nzero", model(32'h80000000, 32'h3F800000), {4'h0, 32'h80000000});
        chk("pin_ovf", model(32'h7F000000, 32'h7F000000), {4'h5, 32'h7F800000});
        chk("pin_unf", model(32'h00800000, 32'h3F000000), {4'h3, 32'h00000000});

        measure("basic", 32'h3FC00000, 32'h40000000, 32'h40400000, 4'h0);
        measure("tie", 32'h3F800001, 32'h3FC00000, TIE_EXP[31:0], 4'h1);
        measure("inf_zero", 32'h7F800000, 32'h00000000, 32'h7FC00000, 4'h8);
        measure("ninf", 32'hFF800000, 32'h40000000, 32'hFF800000, 4'h0);
        measure("nzero", 32'h80000000, 32'h3F800000, 32'h80000000, 4'h0);
        measure("ovf", 32'h7F000000, 32'h7F000000, 32'h7F800000, 4'h5);
        measure("unf", 32'h00800000, 32'h3F000000, 32'h00000000, 4'h3);
        measure("max_exp", 32'h7F000000, 32'h3F800000, 32'h7F000000, 4'h0);
        measure("min_exp", 32'h00800000, 32'h3F800000, 32'h00800000, 4'h0);
        measure("snan", 32'h7F800001, 32'h3F800000, 32'h7FC00000, 4'h8);

        // FP16 instance.
        bus16.valid_i = 1'b1;
        bus16.a_i = 16'h3E00;
        bus16.b_i = 16'h4000;
        @(posedge clk);
        #1;
        bus16.valid_i = 1'b0;
        lat = 1;
        while (!bus16.valid_o && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk("fp16_latency", lat, 5);
        chk("fp16_result", bus16.result_o, 16'h4200);
        chk("fp16_flags", bus16.flags_o, 4'h0);
        @(posedge clk);
        #1;

        // Backpressure: 8 back-to-back pairs, ready_i low for 4 cycles mid-stream.
        cnt0 = out_cnt;
        fork
            begin
                for (int i = 0; i < 8; i++) send(rand_op(), rand_op());
                bus.valid_i = 1'b0;
            end
            begin
                repeat (6) @(posedge clk);
                #1;
                bus.ready_i = 1'b0;
                repeat (4) begin
                    @(negedge clk);
                    chk("bp_ready_low", bus.ready_o, 1'b0);
                end
                @(posedge clk);
                #1;
                bus.ready_i = 1'b1;
            end
        join
        drain();
        chk("bp_count", out_cnt - cnt0, 8);

        // Randomised traffic with random gaps and random downstream stalls.
        rand_rdy = 1'b1;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                bus.valid_i = 1'b0;
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
            send(rand_op(), rand_op());
        end
        bus.valid_i = 1'b0;
        rand_rdy = 1'b0;
        bus.ready_i = 1'b1;
        drain();

        // Reset with three operations in flight and the head stalled at the output.
        bus.ready_i = 1'b0;
        for (int i = 0; i < 3; i++) send(32'h3FC00000, 32'h40000000);
        bus.valid_i = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("pre_rst_valid", bus.valid_o, 1'b1);
        #2;
        rstn = 1'b0;
        #1;
        exp_q.delete();
        chk("mid_rst_valid", bus.valid_o, 1'b0);
        chk("mid_rst_result", bus.result_o, 32'd0);
        chk("mid_rst_flags", bus.flags_o, 4'd0);
        repeat (2) @(negedge clk);
        #2;
        rstn = 1'b1;
        @(posedge clk);
        #1;
        bus.ready_i = 1'b1;
        cnt0 = out_cnt;
        repeat (10) @(posedge clk);
        #1;
        chk("no_stale", out_cnt - cnt0, 0);
        measure("post_rst", 32'h3FC00000, 32'h40000000, 32'h40400000, 4'h0);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end
endmodule
